gpio_aux_irq_ctrl: RTL and testbench

Interrupt controller for the GPIO auxiliary input path. Takes the synchronized `aux_i` vector from the aux input interface and qualifies each bit per pin: enable, edge/level, polarity, both-edge. Results are held in a sticky status register and combined into a single registered `irq`. Sits between `aux_if` and the APB register slave, which drives its simple register port.

---
 rtl/gpio_pkg.sv | 20 ++
 rtl/gpio_aux_evt_gen.sv | 33 +++
 rtl/gpio_aux_irq_ctrl.sv | 130 +++++++++++++
 tb/tb_gpio_aux_irq_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO aux interrupt controller:
// register word indices, handshake FSM states, default width.
package gpio_pkg;

   localparam int DEF_WIDTH = 32;

   localparam logic [2:0] A_IEN   = 3'd0;
   localparam logic [2:0] A_ITYPE = 3'd1;
   localparam logic [2:0] A_IPOL  = 3'd2;
   localparam logic [2:0] A_IBOTH = 3'd3;
   localparam logic [2:0] A_ISTAT = 3'd4;
   localparam logic [2:0] A_IMASK = 3'd5;
   localparam logic [2:0] A_RAW   = 3'd6;

   typedef enum logic {
      IDLE = 1'b0,
      ACK  = 1'b1
   } reg_state_e;

endpackage

// File: rtl/gpio_aux_evt_gen.sv
// Per-pin event qualifier: edge or level detection with polarity
// and both-edge select; edge events are suppressed while priming.
module gpio_aux_evt_gen
   import gpio_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH-1:0] aux_i,
   input  logic [WIDTH-1:0] aux_q,
   input  logic [WIDTH-1:0] itype,
   input  logic [WIDTH-1:0] ipol,
   input  logic [WIDTH-1:0] iboth,
   input  logic             prime,
   output logic [WIDTH-1:0] evt
);

   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] fall;
   logic [WIDTH-1:0] edge_evt;
   logic [WIDTH-1:0] lvl_evt;

   // Combine edge and level events per pin according to ITYPE
   always_comb begin
      rise     = aux_i & ~aux_q;
      fall     = ~aux_i & aux_q;
      edge_evt = (iboth & (rise | fall))
               | (~iboth & ((ipol & rise) | (~ipol & fall)));
      if (prime) edge_evt = '0;
      lvl_evt  = ~(aux_i ^ ipol);
      evt      = (itype & edge_evt) | (~itype & lvl_evt);
   end

endmodule

// File: rtl/gpio_aux_irq_ctrl.sv
// GPIO aux interrupt controller: config registers, sticky status,
// register handshake FSM and the registered irq output.
module gpio_aux_irq_ctrl
   import gpio_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             sys_clk,
   input  logic             sys_rst_n,
   input  logic [WIDTH-1:0] aux_i,
   input  logic             reg_sel,
   input  logic             reg_we,
   input  logic [2:0]       reg_addr,
   input  logic [31:0]      reg_wdata,
   output logic [31:0]      reg_rdata,
   output logic             reg_ack,
   output logic             irq
);

   logic [WIDTH-1:0] ien;
   logic [WIDTH-1:0] itype;
   logic [WIDTH-1:0] ipol;
   logic [WIDTH-1:0] iboth;
   logic [WIDTH-1:0] istat;
   logic [WIDTH-1:0] istat_d;
   logic [WIDTH-1:0] aux_q;
   logic [WIDTH-1:0] evt;
   logic [WIDTH-1:0] wr_w;
   logic [WIDTH-1:0] w1c;
   logic             prime;
   logic             acc;
   logic             wr;
   logic [31:0]      rd_word;
   reg_state_e       state_q;
   reg_state_e       state_d;

   assign wr_w    = reg_wdata[WIDTH-1:0];
   assign wr      = acc & reg_we;
   assign reg_ack = (state_q == ACK);

   gpio_aux_evt_gen #(
      .WIDTH (WIDTH)
   ) u_evt (
      .aux_i (aux_i),
      .aux_q (aux_q),
      .itype (itype),
      .ipol  (ipol),
      .iboth (iboth),
      .prime (prime),
      .evt   (evt)
   );

   // Handshake state register
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) state_q <= IDLE;
      else            state_q <= state_d;
   end

   // Accept one access in IDLE, then spend one cycle in ACK
   always_comb begin
      state_d = state_q;
      acc     = 1'b0;
      case (state_q)
         IDLE: begin
            if (reg_sel) begin
               acc     = 1'b1;
               state_d = ACK;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Read mux, zero-extended to the 32-bit bus
   always_comb begin
      rd_word = '0;
      case (reg_addr)
         A_IEN:   rd_word[WIDTH-1:0] = ien;
         A_ITYPE: rd_word[WIDTH-1:0] = itype;
         A_IPOL:  rd_word[WIDTH-1:0] = ipol;
         A_IBOTH: rd_word[WIDTH-1:0] = iboth;
         A_ISTAT: rd_word[WIDTH-1:0] = istat;
         A_IMASK: rd_word[WIDTH-1:0] = istat & ien;
         A_RAW:   rd_word[WIDTH-1:0] = aux_i;
         default: rd_word = '0;
      endcase
   end

   // Status next value: W1C first, then enabled events (set wins)
   always_comb begin
      w1c     = (wr && reg_addr == A_ISTAT) ? wr_w : '0;
      istat_d = (istat & ~w1c) | (evt & ien);
   end

   // Configuration registers
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         ien   <= '0;
         itype <= '0;
         ipol  <= '0;
         iboth <= '0;
      end else if (wr) begin
         case (reg_addr)
            A_IEN:   ien   <= wr_w;
            A_ITYPE: itype <= wr_w;
            A_IPOL:  ipol  <= wr_w;
            A_IBOTH: iboth <= wr_w;
            default: ;
         endcase
      end
   end

   // Sticky status, input history, priming, irq and read data
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         istat     <= '0;
         aux_q     <= '0;
         prime     <= 1'b1;
         irq       <= 1'b0;
         reg_rdata <= '0;
      end else begin
         istat <= istat_d;
         aux_q <= aux_i;
         prime <= 1'b0;
         irq   <= |(istat & ien);
         if (acc) reg_rdata <= reg_we ? 32'd0 : rd_word;
      end
   end

endmodule

// File: tb/tb_gpio_aux_irq_ctrl.sv
// Directed bench for gpio_aux_irq_ctrl: read expectations are
// queued on request and popped when reg_ack returns data.
module tb_gpio_aux_irq_ctrl;
   import gpio_pkg::*;

   logic        clk;
   logic        rst_n;
   logic [31:0] aux;
   logic        sel;
   logic        we;
   logic [2:0]  addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ack;
   logic        irq;
   logic        ia;

   int          checks;
   int          failures;
   logic [31:0] exp_q[$];
   string       tag_q[$];

   gpio_aux_irq_ctrl #(.WIDTH(32)) dut (
      .sys_clk   (clk),
      .sys_rst_n (rst_n),
      .aux_i     (aux),
      .reg_sel   (sel),
      .reg_we    (we),
      .reg_addr  (addr),
      .reg_wdata (wdata),
      .reg_rdata (rdata),
      .reg_ack   (ack),
      .irq       (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ack(input string tag);
      for (int i = 0; i < 4; i++) begin
         step();
         if (ack === 1'b1) break;
      end
      check({tag, "_ack"}, 32'(ack), 32'd1);
   endtask

   task automatic do_read(input logic [2:0] a, input logic [31:0] e,
                          input string tag, output logic irq_ack);
      exp_q.push_back(e);
      tag_q.push_back(tag);
      sel  = 1'b1;
      we   = 1'b0;
      addr = a;
      wait_ack(tag);
      irq_ack = irq;
      sel = 1'b0;
      if (ack === 1'b1) begin
         check(tag_q.pop_front(), rdata, exp_q.pop_front());
      end else begin
         void'(exp_q.pop_front());
         void'(tag_q.pop_front());
      end
      step();
   endtask

   task automatic do_write(input logic [2:0] a, input logic [31:0] d,
                           output logic irq_ack);
      sel   = 1'b1;
      we    = 1'b1;
      addr  = a;
      wdata = d;
      wait_ack("wr");
      irq_ack = irq;
      sel = 1'b0;
      we  = 1'b0;
      step();
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      aux      = 32'hFFFF_FFFF;
      sel      = 1'b0;
      we       = 1'b0;
      addr     = '0;
      wdata    = '0;

      // reset state, then release with all inputs high
      repeat (3) step();
      check("rst_ack", 32'(ack), 32'd0);
      check("rst_irq", 32'(irq), 32'd0);
      check("rst_rdata", rdata, 32'd0);
      rst_n = 1'b1;
      step();
      step();
      do_write(A_IEN, 32'hFFFF_FFFF, ia);
      do_write(A_ITYPE, 32'hFFFF_FFFF, ia);
      do_write(A_IPOL, 32'hFFFF_FFFF, ia);
      do_read(A_ISTAT, 32'h0, "p1_istat", ia);
      check("p1_irq", 32'(irq), 32'd0);
      do_read(A_IEN, 32'hFFFF_FFFF, "p1_ien_rb", ia);

      // rising edge on bit 0
      do_write(A_IEN, 32'h0, ia);
      aux = 32'h0;
      step();
      do_write(A_IEN, 32'h1, ia);
      do_read(A_ISTAT, 32'h0, "p2_idle", ia);
      aux = 32'h1;
      step();
      check("p2_irq_n1", 32'(irq), 32'd0);
      do_read(A_ISTAT, 32'h1, "p2_istat_n1", ia);
      check("p2_irq_n2", 32'(ia), 32'd1);
      aux = 32'h0;
      step();
      do_read(A_ISTAT, 32'h1, "p2_fall_keeps", ia);
      do_write(A_ISTAT, 32'h1, ia);
      check("p2_irq_m1", 32'(ia), 32'd1);
      check("p2_irq_m2", 32'(irq), 32'd0);
      do_read(A_ISTAT, 32'h0, "p2_clr", ia);

      // both-edge on bit 31, W1C between the two edges
      do_write(A_IEN, 32'h8000_0000, ia);
      do_write(A_IBOTH, 32'h8000_0000, ia);
      aux = 32'h8000_0000;
      step();
      sel   = 1'b1;
      we    = 1'b1;
      addr  = A_ISTAT;
      wdata = 32'h8000_0000;
      step();
      check("p3_w1c_ack", 32'(ack), 32'd1);
      aux = 32'h0;
      sel = 1'b0;
      we  = 1'b0;
      step();
      do_read(A_ISTAT, 32'h8000_0000, "p3_fall_sets", ia);
      do_read(A_IMASK, 32'h8000_0000, "p3_imask", ia);
      do_write(A_ISTAT, 32'h8000_0000, ia);
      do_read(A_ISTAT, 32'h0, "p3_clr", ia);
      check("p3_irq", 32'(irq), 32'd0);

      // level-low on bit 4
      do_write(A_IEN, 32'h0, ia);
      do_write(A_IBOTH, 32'h0, ia);
      do_write(A_ITYPE, 32'h0, ia);
      do_write(A_IPOL, 32'h0, ia);
      do_write(A_IEN, 32'h10, ia);
      do_read(A_ISTAT, 32'h10, "p4_lvl", ia);
      do_write(A_ISTAT, 32'h10, ia);
      do_read(A_ISTAT, 32'h10, "p4_reset", ia);
      do_read(A_IMASK, 32'h10, "p4_imask", ia);
      aux = 32'h10;
      step();
      do_write(A_ISTAT, 32'h10, ia);
      do_read(A_ISTAT, 32'h0, "p4_clr", ia);
      check("p4_irq", 32'(irq), 32'd0);
      do_write(A_IEN, 32'h0, ia);
      aux = 32'h0;
      step();

      // masking and set-vs-clear collision on bit 2
      do_write(A_ITYPE, 32'hFFFF_FFFF, ia);
      do_write(A_IPOL, 32'hFFFF_FFFF, ia);
      do_write(A_IEN, 32'h4, ia);
      aux = 32'h4;
      step();
      step();
      check("p5_irq", 32'(irq), 32'd1);
      do_write(A_IEN, 32'h0, ia);
      check("p5_irq_masked", 32'(irq), 32'd0);
      do_read(A_ISTAT, 32'h4, "p5_istat_kept", ia);
      do_read(A_IMASK, 32'h0, "p5_imask", ia);
      do_write(A_IEN, 32'h4, ia);
      check("p5_irq_unmask", 32'(irq), 32'd1);
      aux = 32'h0;
      step();
      aux   = 32'h4;
      sel   = 1'b1;
      we    = 1'b1;
      addr  = A_ISTAT;
      wdata = 32'h4;
      step();
      check("p5_col_ack", 32'(ack), 32'd1);
      sel = 1'b0;
      we  = 1'b0;
      step();
      do_read(A_ISTAT, 32'h4, "p5_set_wins", ia);
      do_write(A_ISTAT, 32'h4, ia);
      do_read(A_ISTAT, 32'h0, "p5_clr", ia);

      // back-to-back RAW reads with reg_sel held
      do_write(A_IEN, 32'h0, ia);
      aux = 32'hA5A5_1234;
      step();
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(32'hA5A5_1234);
         tag_q.push_back("p6_raw");
      end
      sel  = 1'b1;
      we   = 1'b0;
      addr = A_RAW;
      for (int i = 0; i < 6; i++) begin
         step();
         check("p6_ack_pat", 32'(ack), 32'((i % 2) == 0));
         if (ack === 1'b1 && exp_q.size() > 0) begin
            check(tag_q.pop_front(), rdata, exp_q.pop_front());
         end
      end
      sel = 1'b0;
      step();
      check("p6_sb_empty", 32'(exp_q.size()), 32'd0);
      do_write(3'd7, 32'hFFFF_FFFF, ia);
      do_read(3'd7, 32'h0, "p6_idx7", ia);

      // reset asserted during ACK
      sel  = 1'b1;
      we   = 1'b0;
      addr = A_RAW;
      step();
      check("p6_pre_rst_ack", 32'(ack), 32'd1);
      sel = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      check("p6_rst_ack", 32'(ack), 32'd0);
      check("p6_rst_rdata", rdata, 32'd0);
      step();
      rst_n = 1'b1;
      step();
      do_read(A_IPOL, 32'h0, "p6_ipol_rst", ia);
      do_read(A_RAW, 32'hA5A5_1234, "p6_raw_after", ia);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
